// File: rtl/vector_sequencer.sv
// Control sequencer for the Calculation vector datapath: clears the accumulator,
// streams len operand pairs from memory, waits for the pipeline to drain and captures Sum.
module vector_sequencer #(
    parameter int WIDTH    = 24,
    parameter int LEN_W    = 8,
    parameter int CALC_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [1:0]       mode,
    input  logic             abort,
    output logic             rd_en,
    output logic [LEN_W-1:0] rd_addr,
    input  logic [WIDTH-1:0] rd_a,
    input  logic [WIDTH-1:0] rd_b,
    output logic [WIDTH-1:0] data_1,
    output logic [WIDTH-1:0] data_2,
    output logic             Store_D,
    output logic             E_Square,
    output logic             E_Sum,
    output logic             acc_clr,
    input  logic [WIDTH-1:0] Sum,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             len_err
);

    localparam int DW = (CALC_LAT < 1) ? 1 : $clog2(CALC_LAT + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] len_reg;
    logic [1:0]       mode_reg;
    logic [DW-1:0]    drain_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            len_reg   <= '0;
            mode_reg  <= '0;
            drain_cnt <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            data_1    <= '0;
            data_2    <= '0;
            Store_D   <= 1'b0;
            E_Square  <= 1'b0;
            E_Sum     <= 1'b0;
            acc_clr   <= 1'b0;
            result    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            acc_clr  <= 1'b0;
            done     <= 1'b0;
            len_err  <= 1'b0;
            rd_en    <= 1'b0;
            // Issue stage trails the read strobe by exactly one cycle.
            Store_D  <= rd_en;
            E_Square <= rd_en & mode_reg[1];
            E_Sum    <= rd_en & mode_reg[0];
            if (rd_en) begin
                data_1 <= rd_a;
                data_2 <= rd_b;
            end

            if (abort && (state != IDLE)) begin
                state    <= IDLE;
                busy     <= 1'b0;
                Store_D  <= 1'b0;
                E_Square <= 1'b0;
                E_Sum    <= 1'b0;
            end else begin
                case (state)
                    // DONE accepts a new start so runs can go back to back.
                    IDLE, DONE: begin
                        state <= IDLE;
                        if (start) begin
                            if (len != '0) begin
                                len_reg  <= len;
                                mode_reg <= mode;
                                acc_clr  <= 1'b1;
                                busy     <= 1'b1;
                                state    <= CLEAR;
                            end else begin
                                len_err <= 1'b1;
                            end
                        end
                    end
                    CLEAR: begin
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                        state   <= RUN;
                    end
                    RUN: begin
                        if (rd_addr == len_reg - 1'b1) begin
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end else begin
                            rd_en   <= 1'b1;
                            rd_addr <= rd_addr + 1'b1;
                        end
                    end
                    DRAIN: begin
                        // First DRAIN cycle carries the last issue, then CALC_LAT idle cycles.
                        if (drain_cnt == DW'(CALC_LAT)) begin
                            result <= Sum;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= DONE;
                        end else begin
                            drain_cnt <= drain_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vector_sequencer.sv
// Scoreboard bench for vector_sequencer: a datapath/memory environment, a high-level
// expected-result model and a monitor that checks every acc_clr, issue and done.
module tb_vector_sequencer;

    localparam int W  = 24;
    localparam int LW = 8;
    localparam int L  = 2;

    logic          clk;
    logic          rst;
    logic          start;
    logic [LW-1:0] len;
    logic [1:0]    mode;
    logic          abort;
    logic          rd_en;
    logic [LW-1:0] rd_addr;
    logic [W-1:0]  rd_a;
    logic [W-1:0]  rd_b;
    logic [W-1:0]  data_1;
    logic [W-1:0]  data_2;
    logic          Store_D;
    logic          E_Square;
    logic          E_Sum;
    logic          acc_clr;
    logic [W-1:0]  Sum;
    logic [W-1:0]  result;
    logic          busy;
    logic          done;
    logic          len_err;

    vector_sequencer #(.WIDTH(W), .LEN_W(LW), .CALC_LAT(L)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .mode(mode), .abort(abort),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_a(rd_a), .rd_b(rd_b),
        .data_1(data_1), .data_2(data_2), .Store_D(Store_D), .E_Square(E_Square),
        .E_Sum(E_Sum), .acc_clr(acc_clr), .Sum(Sum), .result(result),
        .busy(busy), .done(done), .len_err(len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Vector memory: data for rd_addr is presented to the issue register in the read cycle.
    logic [W-1:0] mem_a [256];
    logic [W-1:0] mem_b [256];
    assign rd_a = mem_a[rd_addr];
    assign rd_b = mem_b[rd_addr];

    // Calculation datapath: 1-cycle accumulator plus L-1 output register stages (L=2).
    logic [W-1:0] acc;
    logic [W-1:0] acc_d;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            acc_d <= '0;
        end else begin
            if (acc_clr)
                acc <= '0;
            else if (Store_D && E_Sum)
                acc <= E_Square ? W'(acc + W'(data_1 * data_2)) : W'(acc + data_1 + data_2);
            acc_d <= acc;
        end
    end
    assign Sum = acc_d;

    int checks = 0;
    int errors = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [W-1:0] v;
        int           c;
    } done_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sq;
        logic         su;
        int           c;
    } iss_t;

    done_t done_q[$];
    iss_t  iss_q[$];
    int    clr_q[$];

    done_t m_d;
    iss_t  m_s;
    int    m_c;

    always @(negedge clk) begin
        if (!rst) begin
            if (acc_clr) begin
                if (clr_q.size() == 0) chk(1'b0, "acc_clr_unexpected", cyc, -1);
                else begin
                    m_c = clr_q.pop_front();
                    chk(m_c == cyc, "acc_clr_cycle", cyc, m_c);
                end
            end
            if (Store_D) begin
                if (iss_q.size() == 0) chk(1'b0, "issue_unexpected", cyc, -1);
                else begin
                    m_s = iss_q.pop_front();
                    chk(m_s.c == cyc, "issue_cycle", cyc, m_s.c);
                    chk({data_1, data_2, E_Square, E_Sum} == {m_s.a, m_s.b, m_s.sq, m_s.su},
                        "issue_data", {data_1, data_2, E_Square, E_Sum},
                        {m_s.a, m_s.b, m_s.sq, m_s.su});
                end
            end
            if (done) begin
                $display("txn done cycle=%0d result=%0d", cyc, result);
                chk(!busy, "busy_in_done", busy, 0);
                if (done_q.size() == 0) chk(1'b0, "done_unexpected", cyc, -1);
                else begin
                    m_d = done_q.pop_front();
                    chk(m_d.c == cyc, "done_cycle", cyc, m_d.c);
                    chk(result == m_d.v, "result", result, m_d.v);
                end
            end
        end
    end

    // Called at a negedge; pushes expectations from the memory contents and pulses start.
    task automatic start_op(input int n, input logic [1:0] m, input bit exp_done,
                            input int n_issue, output int c0);
        logic [W-1:0] total;
        logic [W-1:0] term;
        c0 = cyc;
        total = '0;
        for (int k = 0; k < n; k++) begin
            term = m[1] ? W'(mem_a[k] * mem_b[k]) : W'(mem_a[k] + mem_b[k]);
            if (m[0]) total = W'(total + term);
        end
        clr_q.push_back(c0 + 1);
        for (int k = 0; k < n_issue; k++)
            iss_q.push_back('{a: mem_a[k], b: mem_b[k], sq: m[1], su: m[0], c: c0 + 3 + k});
        if (exp_done) done_q.push_back('{v: total, c: c0 + n + 3 + L});
        $display("txn start cycle=%0d len=%0d mode=%b expect=%0d", c0, n, m, total);
        len   = LW'(n);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = done;
        end
        if (!got) chk(1'b0, "done_timeout", 0, 1);
    endtask

    task automatic fill_rand(input int n);
        for (int k = 0; k < n; k++) begin
            mem_a[k] = W'($urandom);
            mem_b[k] = W'($urandom);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({busy, done, len_err, rd_en, acc_clr, Store_D, E_Square, E_Sum} == 8'd0,
            {tag, "_ctrl"}, {busy, done, len_err, rd_en, acc_clr, Store_D, E_Square, E_Sum}, 0);
        chk(rd_addr == '0, {tag, "_rd_addr"}, rd_addr, 0);
        chk(data_1 == '0 && data_2 == '0, {tag, "_data"}, {data_1, data_2}, 0);
        chk(result == '0, {tag, "_result"}, result, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int           c0;
    logic [W-1:0] old;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        len   = '0;
        mode  = '0;
        for (int k = 0; k < 256; k++) begin
            mem_a[k] = '0;
            mem_b[k] = '0;
        end
        @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Dot product
        mem_a[0] = 1;  mem_a[1] = 10; mem_a[2] = 40;
        mem_b[0] = 2;  mem_b[1] = 30; mem_b[2] = 77;
        start_op(3, 2'b11, 1'b1, 3, c0);
        wait_done();
        chk(result == 3382, "dot_result", result, 3382);
        chk(cyc - c0 == 8, "dot_done_cycle", cyc - c0, 8);

        // len = 0
        repeat (2) @(negedge clk);
        old   = result;
        len   = '0;
        mode  = 2'b11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk(len_err == 1'b1, "len_err_pulse", len_err, 1);
        chk(busy == 1'b0, "len_err_busy", busy, 0);
        @(negedge clk);
        chk(len_err == 1'b0, "len_err_single", len_err, 0);
        chk(result == old, "len_err_result", result, old);

        // start while busy is ignored
        fill_rand(4);
        start_op(4, 2'b11, 1'b1, 4, c0);
        @(negedge clk);
        len   = 7;
        mode  = 2'b00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (12) @(negedge clk);

        // abort in cycle 4 of a len=5 run
        old = result;
        fill_rand(5);
        start_op(5, 2'b11, 1'b0, 2, c0);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk({busy, rd_en, Store_D, E_Square, E_Sum, acc_clr, done} == 7'd0, "abort_ctrl",
            {busy, rd_en, Store_D, E_Square, E_Sum, acc_clr, done}, 0);
        chk(result == old, "abort_result", result, old);
        repeat (15) @(negedge clk);
        chk(result == old, "abort_result_later", result, old);

        // asynchronous reset mid-RUN
        fill_rand(6);
        start_op(6, 2'b11, 1'b0, 2, c0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1 check_all_zero("async_rst");
        #1 rst = 1'b0;
        @(negedge clk);
        mem_a[0] = 7;
        mem_b[0] = 3;
        start_op(1, 2'b11, 1'b1, 1, c0);
        wait_done();
        chk(result == 21, "post_rst_result", result, 21);
        chk(cyc - c0 == 6, "post_rst_done_cycle", cyc - c0, 6);

        // back-to-back: second start in the done cycle
        fill_rand(5);
        start_op(5, 2'b01, 1'b1, 5, c0);
        wait_done();
        fill_rand(3);
        start_op(3, 2'b11, 1'b1, 3, c0);
        wait_done();

        // randomized runs, mixing back-to-back and idle gaps
        for (int t = 0; t < 25; t++) begin
            int n;
            logic [1:0] m;
            n = $urandom_range(1, 12);
            m = 2'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            fill_rand(n);
            start_op(n, m, 1'b1, n, c0);
            wait_done();
        end

        repeat (10) @(negedge clk);
        chk(done_q.size() == 0, "pending_done", done_q.size(), 0);
        chk(iss_q.size() == 0, "pending_issue", iss_q.size(), 0);
        chk(clr_q.size() == 0, "pending_acc_clr", clr_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
